// File: rtl/mrna_iso_pkg.sv
// Shared types and constants for the mRNA isolation bank sequencer.
package mrna_iso_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StLyse,
    StMix,
    StSep,
    StCollect,
    StFlush,
    StDone
  } state_e;

  localparam int unsigned NUM_VALVES = 13;

  // Valve bit positions within valve_ctrl / valve_flush.
  localparam int unsigned V_COLLECT   = 0;
  localparam int unsigned V_LYSIS_IN  = 1;
  localparam int unsigned V_LYSIS_OUT = 2;
  localparam int unsigned V_PUSH      = 3;
  localparam int unsigned V_PUMP1     = 4;
  localparam int unsigned V_PUMP2     = 5;
  localparam int unsigned V_PUMP3     = 6;
  localparam int unsigned V_SEP       = 7;
  localparam int unsigned V_SIEVE     = 8;
  localparam int unsigned V_WASTE     = 9;
  localparam int unsigned V_BEADS     = 10;
  localparam int unsigned V_CELLS_IN  = 11;
  localparam int unsigned V_CELLS_OUT = 12;

  localparam logic [NUM_VALVES-1:0] VALVES_CLOSED = 13'h1FFF;

  // Pump phase patterns packed as {pump3, pump2, pump1}; 0 = that pump valve open.
  localparam logic [2:0] PUMP_P0 = 3'b110;
  localparam logic [2:0] PUMP_P1 = 3'b101;
  localparam logic [2:0] PUMP_P2 = 3'b011;

  // Valves opened (bit = 1) in each state; pump bits are overlaid separately in MIX.
  function automatic logic [NUM_VALVES-1:0] open_mask(state_e st);
    logic [NUM_VALVES-1:0] m;
    m = '0;
    case (st)
      StLoad: begin
        m[V_CELLS_IN]  = 1'b1;
        m[V_CELLS_OUT] = 1'b1;
        m[V_SIEVE]     = 1'b1;
      end
      StLyse: begin
        m[V_LYSIS_IN]  = 1'b1;
        m[V_LYSIS_OUT] = 1'b1;
      end
      StMix: m[V_BEADS] = 1'b1;
      StSep: begin
        m[V_SEP]   = 1'b1;
        m[V_WASTE] = 1'b1;
      end
      StCollect: begin
        m[V_PUSH]    = 1'b1;
        m[V_COLLECT] = 1'b1;
      end
      default: m = '0;
    endcase
    return m;
  endfunction

  function automatic logic [2:0] pump_pattern(logic [1:0] phase);
    case (phase)
      2'd0:    return PUMP_P0;
      2'd1:    return PUMP_P1;
      default: return PUMP_P2;
    endcase
  endfunction

endpackage

// File: rtl/pump_phase_gen.sv
// Three-phase peristaltic pump sequencer: phase dwell, phase index and rotation count.
module pump_phase_gen
  import mrna_iso_pkg::*;
#(
  parameter int unsigned PHASE_T = 4,
  parameter int unsigned MIX_ROT = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic       clr_i,
  output logic [2:0] pattern_o,   // pattern for the coming cycle; registered by the caller
  output logic       rot_done_o   // high in the final cycle of the last rotation
);

  localparam int unsigned PW = (PHASE_T < 2) ? 1 : $clog2(PHASE_T);
  localparam int unsigned RW = (MIX_ROT < 2) ? 1 : $clog2(MIX_ROT);
  localparam logic [PW-1:0] PhaseLast = PW'(PHASE_T - 1);
  localparam logic [RW-1:0] RotLast   = RW'((MIX_ROT == 0) ? 0 : MIX_ROT - 1);

  logic [PW-1:0] dwell_q, dwell_d;
  logic [1:0]    phase_q, phase_d;
  logic [RW-1:0] rot_q, rot_d;
  logic          phase_end, wrap;

  assign phase_end  = (dwell_q == PhaseLast);
  assign wrap       = phase_end && (phase_q == 2'd2);
  assign rot_done_o = en_i && wrap && (rot_q == RotLast);
  assign pattern_o  = pump_pattern(phase_d);

  // Advance dwell, then phase on dwell expiry, then rotation on P2->P0 wrap.
  always_comb begin
    dwell_d = dwell_q;
    phase_d = phase_q;
    rot_d   = rot_q;
    if (clr_i) begin
      dwell_d = '0;
      phase_d = 2'd0;
      rot_d   = '0;
    end else if (en_i) begin
      if (phase_end) begin
        dwell_d = '0;
        phase_d = wrap ? 2'd0 : phase_q + 2'd1;
        if (wrap) rot_d = rot_q + 1'b1;
      end else begin
        dwell_d = dwell_q + 1'b1;
      end
    end
  end

  // Counter registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dwell_q <= '0;
      phase_q <= 2'd0;
      rot_q   <= '0;
    end else begin
      dwell_q <= dwell_d;
      phase_q <= phase_d;
      rot_q   <= rot_d;
    end
  end

endmodule

// File: rtl/mrna_iso_sequencer.sv
// Timed valve sequencer for one mRNA isolation bank: load, lyse, mix, separate, collect, flush.
module mrna_iso_sequencer
  import mrna_iso_pkg::*;
#(
  parameter int unsigned LOAD_T    = 8,
  parameter int unsigned LYSE_T    = 8,
  parameter int unsigned PHASE_T   = 4,
  parameter int unsigned MIX_ROT   = 16,
  parameter int unsigned SEP_T     = 8,
  parameter int unsigned COLLECT_T = 8,
  parameter int unsigned FLUSH_T   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic                  hold_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  aborted_o,
  output logic [NUM_VALVES-1:0] valve_ctrl_o,
  output logic [NUM_VALVES-1:0] valve_flush_o
);

  localparam int unsigned M0   = (LOAD_T > LYSE_T) ? LOAD_T : LYSE_T;
  localparam int unsigned M1   = (M0 > PHASE_T) ? M0 : PHASE_T;
  localparam int unsigned M2   = (M1 > SEP_T) ? M1 : SEP_T;
  localparam int unsigned M3   = (M2 > COLLECT_T) ? M2 : COLLECT_T;
  localparam int unsigned MaxT = (M3 > FLUSH_T) ? M3 : FLUSH_T;
  localparam int unsigned CntW = $clog2(MaxT) + 1;

  state_e                state_q, state_d;
  logic [CntW-1:0]       dwell_q, dwell_d;
  logic                  aborted_q, aborted_d;
  logic                  busy_q, done_q;
  logic [NUM_VALVES-1:0] ctrl_q, ctrl_d, flush_q, flush_d;
  logic                  enter, active;
  logic                  pump_en, pump_clr, rot_done;
  logic [2:0]            pump_pat;

  // Dwell is loaded with T-1 on entry and the state leaves when it reaches zero.
  function automatic logic [CntW-1:0] dwell_load(state_e st);
    case (st)
      StLoad:    return CntW'(LOAD_T - 1);
      StLyse:    return CntW'(LYSE_T - 1);
      StSep:     return CntW'(SEP_T - 1);
      StCollect: return CntW'(COLLECT_T - 1);
      StFlush:   return CntW'(FLUSH_T - 1);
      default:   return '0;
    endcase
  endfunction

  assign active = (state_q == StLoad) || (state_q == StLyse) || (state_q == StMix) ||
                  (state_q == StSep) || (state_q == StCollect);

  assign pump_clr = (state_q != StMix);
  assign pump_en  = (state_q == StMix) && !hold_i;

  pump_phase_gen #(
    .PHASE_T (PHASE_T),
    .MIX_ROT (MIX_ROT)
  ) u_pump (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en_i       (pump_en),
    .clr_i      (pump_clr),
    .pattern_o  (pump_pat),
    .rot_done_o (rot_done)
  );

  // Next state, dwell and sticky abort flag; abort overrides hold.
  always_comb begin
    state_d   = state_q;
    dwell_d   = dwell_q;
    aborted_d = aborted_q;
    enter     = 1'b0;
    if (abort_i && active) begin
      state_d   = StFlush;
      enter     = 1'b1;
      aborted_d = 1'b1;
    end else if (!hold_i) begin
      case (state_q)
        StIdle: begin
          if (start_i) begin
            state_d   = StLoad;
            enter     = 1'b1;
            aborted_d = 1'b0;
          end
        end
        StLoad: begin
          if (dwell_q == '0) begin
            state_d = StLyse;
            enter   = 1'b1;
          end
        end
        StLyse: begin
          if (dwell_q == '0) begin
            state_d = (MIX_ROT == 0) ? StSep : StMix;
            enter   = 1'b1;
          end
        end
        StMix: begin
          if (rot_done) begin
            state_d = StSep;
            enter   = 1'b1;
          end
        end
        StSep: begin
          if (dwell_q == '0) begin
            state_d = StCollect;
            enter   = 1'b1;
          end
        end
        StCollect: begin
          if (dwell_q == '0) begin
            state_d = StFlush;
            enter   = 1'b1;
          end
        end
        StFlush: begin
          if (dwell_q == '0) begin
            state_d = StDone;
            enter   = 1'b1;
          end
        end
        StDone: begin
          state_d = StIdle;
          enter   = 1'b1;
        end
        default: begin
          state_d = StIdle;
          enter   = 1'b1;
        end
      endcase
      if (!enter && dwell_q != '0) dwell_d = dwell_q - 1'b1;
    end
    if (enter) dwell_d = dwell_load(state_d);
    if (abort_i && state_q == StFlush) aborted_d = 1'b1;
  end

  // Valve outputs are decoded from the next state so they line up with the state register.
  always_comb begin
    ctrl_d = ~open_mask(state_d);
    if (state_d == StMix) ctrl_d[V_PUMP1 +: 3] = pump_pat;
    flush_d = (state_d == StFlush) ? VALVES_CLOSED : '0;
  end

  // State and registered outputs; reset closes every valve with no flush.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      dwell_q   <= '0;
      aborted_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ctrl_q    <= VALVES_CLOSED;
      flush_q   <= '0;
    end else begin
      state_q   <= state_d;
      dwell_q   <= dwell_d;
      aborted_q <= aborted_d;
      busy_q    <= (state_d != StIdle);
      done_q    <= (state_d == StDone);
      ctrl_q    <= ctrl_d;
      flush_q   <= flush_d;
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign aborted_o     = aborted_q;
  assign valve_ctrl_o  = ctrl_q;
  assign valve_flush_o = flush_q;

endmodule
